// File: rtl/wdt_window_timer.sv
// ---------------------------------------------------------------------------
// wdt_window_timer
//   Windowed watchdog timer. Counts enabled cycles and raises a level warning
//   interrupt once the warn threshold is reached. It issues a fixed-length
//   reset pulse on timeout, or when a valid service arrives too early (inside
//   the closed window). The runtime thresholds can be locked. The block also
//   keeps a saturating count of bites.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   en                run enable (forced on once locked)
//   cfg_we            write cfg_timeout / cfg_warn / cfg_window
//   cfg_timeout       new timeout threshold
//   cfg_warn          new warning threshold
//   cfg_window        new closed-window length
//   lock              set sticky config lock (cleared only by rst)
//   kick, kick_key    one-cycle service strobe with its key
//   cnt               current count
//   state             0 IDLE, 1 RUN, 2 WARN, 3 BITE
//   warn_irq          high while in WARN
//   wdt_rst           high while in BITE (RST_PULSE cycles)
//   err_early         pulse: valid key while cnt < window
//   err_key           pulse: kick with wrong key
//   cfg_err           pulse: config write rejected
//   bite_cnt          saturating bite count
// ---------------------------------------------------------------------------
module wdt_window_timer #(
   parameter int                 CNT_W     = 32,
   parameter logic [CNT_W-1:0]   TO_DEF    = CNT_W'(32'h3FFFFFFF),
   parameter logic [CNT_W-1:0]   WARN_DEF  = CNT_W'(32'h30000000),
   parameter logic [CNT_W-1:0]   WIN_DEF   = '0,
   parameter int                 RST_PULSE = 16,
   parameter logic [15:0]        KEY       = 16'hA5C3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_timeout,
   input  logic [CNT_W-1:0] cfg_warn,
   input  logic [CNT_W-1:0] cfg_window,
   input  logic             lock,
   input  logic             kick,
   input  logic [15:0]      kick_key,
   output logic [CNT_W-1:0] cnt,
   output logic [1:0]       state,
   output logic             warn_irq,
   output logic             wdt_rst,
   output logic             err_early,
   output logic             err_key,
   output logic             cfg_err,
   output logic [7:0]       bite_cnt
);

   localparam int            PW         = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
   localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WARN = 2'd2,
      S_BITE = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
   logic [CNT_W-1:0] timeout_reg, warn_reg, window_reg;
   logic             locked_reg;
   logic [PW-1:0]    pulse_reg, pulse_next;
   logic [7:0]       bite_cnt_reg;
   logic             err_early_reg, err_early_next;
   logic             err_key_reg, err_key_next;
   logic             cfg_err_reg;
   logic             run, key_ok, cfg_ok, bite_entry;

   assign run     = en | locked_reg;
   assign key_ok  = (kick_key == KEY);
   assign cnt_inc = cnt_reg + CNT_W'(1);
   assign cfg_ok  = !locked_reg && (cfg_warn != '0) &&
                    (cfg_warn < cfg_timeout) && (cfg_window < cfg_timeout);
   assign bite_entry = (state_next == S_BITE) && (state_reg != S_BITE);

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      pulse_next     = pulse_reg;
      err_early_next = 1'b0;
      err_key_next   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            cnt_next = '0;
            if (run) state_next = S_RUN;
         end
         S_RUN, S_WARN: begin
            if (!run) begin
               state_next = S_IDLE;
               cnt_next   = '0;
            end else begin
               // A wrong key is flagged but otherwise falls through to the
               // timeout / count logic below.
               if (kick && !key_ok) err_key_next = 1'b1;
               if (kick && key_ok && cnt_reg >= window_reg) begin
                  state_next = S_RUN;
                  cnt_next   = '0;
               end else if (kick && key_ok) begin
                  err_early_next = 1'b1;
                  state_next     = S_BITE;
                  cnt_next       = '0;
                  pulse_next     = '0;
               end else if (cnt_reg >= timeout_reg) begin
                  // >= so a timeout lowered below the running count still bites.
                  state_next = S_BITE;
                  cnt_next   = '0;
                  pulse_next = '0;
               end else begin
                  cnt_next = cnt_inc;
                  if (state_reg == S_RUN && cnt_inc >= warn_reg) state_next = S_WARN;
               end
            end
         end
         S_BITE: begin
            cnt_next = '0;
            if (pulse_reg == PULSE_LAST) begin
               state_next = run ? S_RUN : S_IDLE;
               pulse_next = '0;
            end else begin
               pulse_next = pulse_reg + PW'(1);
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         pulse_reg     <= '0;
         timeout_reg   <= TO_DEF;
         warn_reg      <= WARN_DEF;
         window_reg    <= WIN_DEF;
         locked_reg    <= 1'b0;
         bite_cnt_reg  <= 8'd0;
         err_early_reg <= 1'b0;
         err_key_reg   <= 1'b0;
         cfg_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         pulse_reg     <= pulse_next;
         err_early_reg <= err_early_next;
         err_key_reg   <= err_key_next;
         cfg_err_reg   <= cfg_we && !cfg_ok;
         if (cfg_we && cfg_ok) begin
            timeout_reg <= cfg_timeout;
            warn_reg    <= cfg_warn;
            window_reg  <= cfg_window;
         end
         if (lock) locked_reg <= 1'b1;
         if (bite_entry && bite_cnt_reg != 8'hFF) bite_cnt_reg <= bite_cnt_reg + 8'd1;
      end
   end

   assign cnt       = cnt_reg;
   assign state     = state_reg;
   assign warn_irq  = (state_reg == S_WARN);
   assign wdt_rst   = (state_reg == S_BITE);
   assign err_early = err_early_reg;
   assign err_key   = err_key_reg;
   assign cfg_err   = cfg_err_reg;
   assign bite_cnt  = bite_cnt_reg;

endmodule
